// File: rtl/tank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tank_pkg
//  Description : Types and constants shared by the tank and bullet logic:
//                the 16x16 wall map, map limits, direction and bullet-state
//                encodings, and bit offsets of the packed 32-bit object word.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package tank_pkg;

    // Each map cell is 32x32 pixels; the playfield is 512x512.
    localparam int TILE_SHIFT = 5;
    localparam int MAP_MAX    = 511;

    // Wall map indexed [x_cell][y_cell]. Each 16-bit literal is one x column,
    // with y_cell 0 as the left-most bit. The border is solid and there is a
    // small 2x2 block in the middle of the field.
    localparam logic [0:15][0:15] TILE_MAP = '{
        16'b1111_1111_1111_1111,  // x = 0
        16'b1000_0000_0000_0001,  // x = 1
        16'b1000_0000_0000_0001,  // x = 2
        16'b1000_0000_0000_0001,  // x = 3
        16'b1000_0000_0000_0001,  // x = 4
        16'b1000_0000_0000_0001,  // x = 5
        16'b1000_0000_0000_0001,  // x = 6
        16'b1000_0001_1000_0001,  // x = 7
        16'b1000_0001_1000_0001,  // x = 8
        16'b1000_0000_0000_0001,  // x = 9
        16'b1000_0000_0000_0001,  // x = 10
        16'b1000_0000_0000_0001,  // x = 11
        16'b1000_0000_0000_0001,  // x = 12
        16'b1000_0000_0000_0001,  // x = 13
        16'b1000_0000_0000_0001,  // x = 14
        16'b1111_1111_1111_1111   // x = 15
    };

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLY     = 2'd1,
        EXPLODE = 2'd2
    } bullet_state_e;

    // Object word: {rsvd, type[1:0], alive, x[9:0], y[9:0], dir[1:0],
    //               rom_row[2:0], rom_col[2:0]}
    localparam int OBJ_ROM_COL_LSB = 0;
    localparam int OBJ_ROM_ROW_LSB = 3;
    localparam int OBJ_DIR_LSB     = 6;
    localparam int OBJ_Y_LSB       = 8;
    localparam int OBJ_X_LSB       = 18;
    localparam int OBJ_ALIVE_BIT   = 28;
    localparam int OBJ_TYPE_LSB    = 29;

    function automatic logic tile_is_wall(input logic [3:0] x_cell,
                                          input logic [3:0] y_cell);
        return TILE_MAP[x_cell][y_cell];
    endfunction

endpackage : tank_pkg
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tick_divider
//  Description : Free-running 0..SPEED_DIV-1 counter that emits a one-clock
//                tick on the wrap cycle. A synchronous restart clears it to 0
//                and a low enable freezes it.
//  Ports       : clk        game clock
//                reset_n    asynchronous active-low reset
//                i_enable   advance the counter (low = hold)
//                i_restart  clear the counter to 0 (when enabled)
//                o_tick     high on the cycle the counter wraps
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_divider #(
    parameter int SPEED_DIV = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_enable,
    input  logic i_restart,
    output logic o_tick
);

    if (SPEED_DIV < 1 || SPEED_DIV > 255) begin : g_bad_speed_div
        $error("tick_divider: SPEED_DIV must be in 1..255");
    end

    localparam logic [7:0] c_last = 8'(SPEED_DIV - 1);

    logic [7:0] r_cnt;

    assign o_tick = i_enable && (r_cnt == c_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 8'd0;
        end else if (i_enable) begin
            if (i_restart || r_cnt == c_last) begin
                r_cnt <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule : tick_divider
`default_nettype wire

// File: rtl/bullet_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bullet_ctrl
//  Description : Bullet owned by one tank. Spawns on the tank's fire pulse,
//                moves STEP pixels per move tick, stops on walls or on the
//                enemy tank (pulsing hit), shows a short explosion, and
//                publishes a packed 32-bit object word for the sprite path.
//                Optional macro BULLET_RANGE_LIMIT_EN: the bullet explodes
//                (no hit) after MAX_STEPS completed moves.
//  Ports       : clk, reset_n            clock, async active-low reset
//                game_over               freeze everything, force hit low
//                fire, direction         spawn request and heading
//                tank_x, tank_y          owning tank top-left corner
//                enemy_x, enemy_y        enemy tank top-left corner
//                enemy_active            enemy tank is alive
//                hit                     one-cycle pulse to enemy's killed
//                busy                    bullet is in flight or exploding
//                pos_x, pos_y            bullet top-left corner (8x8 sprite)
//                bullet_state            packed object word
//  Revision    : 1.0 - initial release
// ============================================================================
module bullet_ctrl
    import tank_pkg::*;
#(
    parameter int          STEP           = 8,
    parameter int          SPEED_DIV      = 1,
    parameter int          EXPLODE_CYCLES = 4,
    parameter logic [1:0]  OBJ_TYPE       = 2'b11,
    parameter int          MAX_STEPS      = 40
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        game_over,
    input  logic        fire,
    input  logic [1:0]  direction,
    input  logic [9:0]  tank_x,
    input  logic [9:0]  tank_y,
    input  logic [9:0]  enemy_x,
    input  logic [9:0]  enemy_y,
    input  logic        enemy_active,
    output logic        hit,
    output logic        busy,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic [31:0] bullet_state
);

    if (EXPLODE_CYCLES < 1 || EXPLODE_CYCLES > 255) begin : g_bad_explode
        $error("bullet_ctrl: EXPLODE_CYCLES must be in 1..255");
    end
    if (MAX_STEPS < 1) begin : g_bad_max_steps
        $error("bullet_ctrl: MAX_STEPS must be at least 1");
    end

    localparam logic signed [11:0] c_step     = 12'(STEP);
    localparam logic [7:0]         c_exp_last = 8'(EXPLODE_CYCLES - 1);

    bullet_state_e r_state;
    dir_e          r_dir;
    logic [9:0]    r_pos_x;
    logic [9:0]    r_pos_y;
    logic          r_hit;
    logic [7:0]    r_exp_cnt;

`ifdef BULLET_RANGE_LIMIT_EN
    localparam int                  c_steps_w = $clog2(MAX_STEPS + 1);
    localparam logic [c_steps_w-1:0] c_max    = c_steps_w'(MAX_STEPS);
    logic [c_steps_w-1:0] r_steps;
`endif

    logic w_run;
    logic w_spawn;
    logic w_tick;

    assign w_run   = !game_over;
    assign w_spawn = w_run && fire && (r_state == IDLE);

    tick_divider #(
        .SPEED_DIV (SPEED_DIV)
    ) u_tick_divider (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_enable  (w_run),
        .i_restart (w_spawn),
        .o_tick    (w_tick)
    );

    // ------------------------------------------------------------------
    // Candidate position. Arithmetic is 12-bit signed so that a move past
    // the top or left edge shows up as a negative coordinate instead of
    // wrapping to a large 10-bit value.
    // ------------------------------------------------------------------
    logic signed [11:0] w_px, w_py;
    logic signed [11:0] w_cand_x, w_cand_y;
    logic signed [11:0] w_lead_x, w_lead_y;
    logic signed [11:0] w_ex, w_ey;
    logic [3:0]         w_cell_x, w_cell_y;
    logic               w_outside;
    logic               w_wall;
    logic               w_overlap;

    assign w_px = signed'({2'b00, r_pos_x});
    assign w_py = signed'({2'b00, r_pos_y});
    assign w_ex = signed'({2'b00, enemy_x});
    assign w_ey = signed'({2'b00, enemy_y});

    // The leading edge is the side of the 8x8 box facing the motion; only
    // that coordinate changes, the other one stays the top-left value.
    always_comb begin
        w_cand_x = w_px;
        w_cand_y = w_py;
        w_lead_x = w_px;
        w_lead_y = w_py;
        case (r_dir)
            UP: begin
                w_cand_y = w_py - c_step;
                w_lead_y = w_cand_y;
            end
            DOWN: begin
                w_cand_y = w_py + c_step;
                w_lead_y = w_cand_y + 12'sd7;
            end
            LEFT: begin
                w_cand_x = w_px - c_step;
                w_lead_x = w_cand_x;
            end
            default: begin
                w_cand_x = w_px + c_step;
                w_lead_x = w_cand_x + 12'sd7;
            end
        endcase
    end

    assign w_outside = (w_lead_x < 12'sd0) || (w_lead_x > 12'(MAP_MAX)) ||
                       (w_lead_y < 12'sd0) || (w_lead_y > 12'(MAP_MAX));
    assign w_cell_x  = 4'(w_lead_x >>> TILE_SHIFT);
    assign w_cell_y  = 4'(w_lead_y >>> TILE_SHIFT);
    // The map lookup is meaningless off the field, so outside wins first.
    assign w_wall    = w_outside || tile_is_wall(w_cell_x, w_cell_y);

    // 8x8 candidate box against the 32x32 enemy box, edges inclusive.
    assign w_overlap = enemy_active &&
                       (w_cand_x <= w_ex + 12'sd31) && (w_cand_x + 12'sd7 >= w_ex) &&
                       (w_cand_y <= w_ey + 12'sd31) && (w_cand_y + 12'sd7 >= w_ey);

    // ------------------------------------------------------------------
    // Bullet state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_dir     <= UP;
            r_pos_x   <= 10'd0;
            r_pos_y   <= 10'd0;
            r_hit     <= 1'b0;
            r_exp_cnt <= 8'd0;
`ifdef BULLET_RANGE_LIMIT_EN
            r_steps   <= '0;
`endif
        end else if (game_over) begin
            // Everything holds; only the hit pulse is squashed.
            r_hit <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (fire) begin
                        r_state   <= FLY;
                        r_dir     <= dir_e'(direction);
                        r_pos_x   <= tank_x + 10'd12;
                        r_pos_y   <= tank_y + 10'd12;
                        r_exp_cnt <= 8'd0;
`ifdef BULLET_RANGE_LIMIT_EN
                        r_steps   <= '0;
`endif
                    end
                end
                FLY: begin
                    if (w_tick) begin
                        if (w_overlap) begin
                            r_hit   <= 1'b1;
                            r_state <= EXPLODE;
                        end else if (w_wall) begin
                            r_state <= EXPLODE;
`ifdef BULLET_RANGE_LIMIT_EN
                        end else if (r_steps == c_max) begin
                            r_state <= EXPLODE;
`endif
                        end else begin
                            r_pos_x <= w_cand_x[9:0];
                            r_pos_y <= w_cand_y[9:0];
`ifdef BULLET_RANGE_LIMIT_EN
                            r_steps <= r_steps + 1'b1;
`endif
                        end
                    end
                end
                EXPLODE: begin
                    if (w_tick) begin
                        if (r_exp_cnt == c_exp_last) begin
                            r_state   <= IDLE;
                            r_exp_cnt <= 8'd0;
                        end else begin
                            r_exp_cnt <= r_exp_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs and object word
    // ------------------------------------------------------------------
    logic        w_alive;
    logic [2:0]  w_rom_col;
    logic [31:0] w_word;

    assign w_alive = (r_state != IDLE);

    always_comb begin
        w_rom_col = {1'b0, r_dir};
        if (r_state == EXPLODE) begin
            // Explosion frames 4..7, saturating on the last frame.
            w_rom_col = (r_exp_cnt >= 8'd3) ? 3'd7 : (3'd4 + r_exp_cnt[2:0]);
        end
    end

    always_comb begin
        w_word                            = '0;
        w_word[OBJ_TYPE_LSB +: 2]         = OBJ_TYPE;
        w_word[OBJ_ALIVE_BIT]             = w_alive;
        w_word[OBJ_X_LSB +: 10]           = r_pos_x;
        w_word[OBJ_Y_LSB +: 10]           = r_pos_y;
        w_word[OBJ_DIR_LSB +: 2]          = r_dir;
        w_word[OBJ_ROM_ROW_LSB +: 3]      = 3'b001;
        w_word[OBJ_ROM_COL_LSB +: 3]      = w_rom_col;
    end

    assign hit          = r_hit;
    assign busy         = w_alive;
    assign pos_x        = r_pos_x;
    assign pos_y        = r_pos_y;
    assign bullet_state = w_word;

endmodule : bullet_ctrl
`default_nettype wire

// File: tb/tb_bullet_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bullet_ctrl
//  Description : Directed self-checking bench for bullet_ctrl with STEP=8,
//                SPEED_DIV=1, EXPLODE_CYCLES=4. Expected values are worked
//                out by hand from the tank/enemy coordinates and wall map.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bullet_ctrl;

`ifdef BULLET_RANGE_LIMIT_EN
    localparam int c_max_steps = 5;
`else
    localparam int c_max_steps = 40;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        game_over;
    logic        fire;
    logic [1:0]  direction;
    logic [9:0]  tank_x, tank_y;
    logic [9:0]  enemy_x, enemy_y;
    logic        enemy_active;
    logic        hit;
    logic        busy;
    logic [9:0]  pos_x, pos_y;
    logic [31:0] bullet_state;

    int n_vec    = 0;
    int n_err    = 0;
    int hit_seen = 0;

    bullet_ctrl #(
        .STEP           (8),
        .SPEED_DIV      (1),
        .EXPLODE_CYCLES (4),
        .OBJ_TYPE       (2'b11),
        .MAX_STEPS      (c_max_steps)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .game_over    (game_over),
        .fire         (fire),
        .direction    (direction),
        .tank_x       (tank_x),
        .tank_y       (tank_y),
        .enemy_x      (enemy_x),
        .enemy_y      (enemy_y),
        .enemy_active (enemy_active),
        .hit          (hit),
        .busy         (busy),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .bullet_state (bullet_state)
    );

    always #5 clk = ~clk;

    // Counts every cycle on which hit is high, sampled mid-cycle.
    always @(negedge clk) begin
        if (hit === 1'b1) hit_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance n active edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] obj(input logic alive, input logic [9:0] x,
                                        input logic [9:0] y, input logic [1:0] d,
                                        input logic [2:0] col);
        return {1'b0, 2'b11, alive, x, y, d, 3'b001, col};
    endfunction

    task automatic spawn(input logic [1:0] d);
        direction = d;
        fire      = 1'b1;
        step(1);
        fire      = 1'b0;
    endtask

    int h0;

    initial begin
        reset_n      = 1'b0;
        game_over    = 1'b0;
        fire         = 1'b0;
        direction    = 2'b00;
        tank_x       = 10'd32;
        tank_y       = 10'd32;
        enemy_x      = 10'd128;
        enemy_y      = 10'd32;
        enemy_active = 1'b0;

        // Reset state
        step(2);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hit", {31'd0, hit}, 32'd0);
        check("reset_pos", {12'd0, pos_x, pos_y}, 32'd0);
        check("reset_word", bullet_state, 32'h6000_0008);
        reset_n = 1'b1;
        step(1);

        // Left shot: one move to x=36, then cell (0,1) is a wall.
        h0 = hit_seen;
        spawn(2'b10);
        check("left_spawn", bullet_state, obj(1'b1, 10'd44, 10'd44, 2'b10, 3'd2));
        step(1);
        check("left_move", bullet_state, obj(1'b1, 10'd36, 10'd44, 2'b10, 3'd2));
        step(1);
        check("left_wall", bullet_state, obj(1'b1, 10'd36, 10'd44, 2'b10, 3'd4));
        step(4);
        check("left_idle", {31'd0, busy}, 32'd0);
        check("left_nohit", hit_seen - h0, 32'd0);

        // Up shot with fire held high from the first FLY cycle onward.
        h0 = hit_seen;
        spawn(2'b00);
        check("up_spawn", {12'd0, pos_x, pos_y}, {12'd0, 10'd44, 10'd44});
        check("up_busy", {31'd0, busy}, 32'd1);
        step(1);
        check("up_move", bullet_state, obj(1'b1, 10'd44, 10'd36, 2'b00, 3'd0));
        direction = 2'b11;
        fire      = 1'b1;
        step(1);
        check("up_wall", bullet_state, obj(1'b1, 10'd44, 10'd36, 2'b00, 3'd4));
        step(1);
        check("up_exp1", bullet_state, obj(1'b1, 10'd44, 10'd36, 2'b00, 3'd5));
        step(2);
        check("up_exp3", bullet_state, obj(1'b1, 10'd44, 10'd36, 2'b00, 3'd7));
        step(1);
        check("up_idle", bullet_state, obj(1'b0, 10'd44, 10'd36, 2'b00, 3'd0));
        check("up_nohit", hit_seen - h0, 32'd0);
        // fire still high: first IDLE cycle spawns the right-going bullet
        step(1);
        fire = 1'b0;
        check("respawn", bullet_state, obj(1'b1, 10'd44, 10'd44, 2'b11, 3'd3));

`ifndef BULLET_RANGE_LIMIT_EN
        // Right shot with no enemy: 53 moves to x=468, then the east wall.
        h0 = hit_seen;
        step(53);
        check("right_fly", bullet_state, obj(1'b1, 10'd468, 10'd44, 2'b11, 3'd3));
        step(1);
        check("right_wall", bullet_state, obj(1'b1, 10'd468, 10'd44, 2'b11, 3'd4));
        step(4);
        check("right_idle", {31'd0, busy}, 32'd0);
        check("right_nohit", hit_seen - h0, 32'd0);

        // Active enemy at (128,32): nine moves to x=116, tenth tick hits.
        enemy_active = 1'b1;
        h0 = hit_seen;
        spawn(2'b11);
        step(9);
        check("enemy_approach", {21'd0, hit, pos_x}, {21'd0, 1'b0, 10'd116});
        step(1);
        check("enemy_hit", {21'd0, hit, pos_x}, {21'd0, 1'b1, 10'd116});
        check("enemy_word", bullet_state, obj(1'b1, 10'd116, 10'd44, 2'b11, 3'd4));
        step(1);
        check("enemy_hit_end", {31'd0, hit}, 32'd0);
        check("enemy_hit_once", hit_seen - h0, 32'd1);
        step(3);
        check("enemy_idle", {31'd0, busy}, 32'd0);

        // Inactive enemy: the bullet passes through.
        enemy_active = 1'b0;
        h0 = hit_seen;
        spawn(2'b11);
        step(11);
        check("ghost_pass", {22'd0, pos_x}, {22'd0, 10'd132});

        // game_over freeze for 20 cycles, with fire attempted.
        game_over = 1'b1;
        fire      = 1'b1;
        step(20);
        fire      = 1'b0;
        check("freeze_word", bullet_state, obj(1'b1, 10'd132, 10'd44, 2'b11, 3'd3));
        check("freeze_nohit", hit_seen - h0, 32'd0);
        game_over = 1'b0;
        step(1);
        check("resume", {22'd0, pos_x}, {22'd0, 10'd140});
`else
        // Range limit: five moves to x=84, sixth tick explodes without hit.
        h0 = hit_seen;
        step(5);
        check("range_fly", bullet_state, obj(1'b1, 10'd84, 10'd44, 2'b11, 3'd3));
        step(1);
        check("range_explode", bullet_state, obj(1'b1, 10'd84, 10'd44, 2'b11, 3'd4));
        check("range_nohit", hit_seen - h0, 32'd0);
        spawn(2'b11);
        spawn(2'b11);
`endif

        // Asynchronous reset between edges while a bullet is live.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_pos", {12'd0, pos_x, pos_y}, 32'd0);
        check("async_word", bullet_state, 32'h6000_0008);
        step(2);
        reset_n = 1'b1;
        step(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bullet_ctrl
`default_nettype wire
